// File: rtl/keypad_scan_deb.sv
// rtl/keypad_scan_deb.sv - matrix keypad column scanner with tick-based debounce and held flag
// Optional 7-segment phone-layout decode on port s when KEYPAD_SEG7_EN is defined.
module keypad_scan_deb #(
    parameter int ROWS      = 4,
    parameter int COLS      = 3,
    parameter int DIV_W     = 14,
    parameter int DEB_TICKS = 4,
    localparam int CW       = $clog2(ROWS * COLS)
) (
    input  logic            ck,
    input  logic            rst,
    input  logic [ROWS-1:0] R,
    output logic [COLS-1:0] C,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held
`ifdef KEYPAD_SEG7_EN
    ,
    output logic [6:0]      s
`endif
);
    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

    state_t          state, state_nx;
    logic [ROWS-1:0] r_meta, rs, pat, pat_nx;
    logic [DIV_W-1:0] div;
    logic            tick;
    logic [3:0]      cnt, cnt_nx;
    logic [4:0]      cnt_inc;
    logic [CLW-1:0]  col_idx;
    logic [RW-1:0]   row_idx, row_nx;
    logic            single, rotate, accept, held_nx;

    function automatic logic [RW-1:0] onehot_idx(input logic [ROWS-1:0] v);
        onehot_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) onehot_idx = RW'(i);
        end
    endfunction

    assign tick    = (div == '1);
    assign cnt_inc = {1'b0, cnt} + 5'd1;
    // Zero or several rows asserted means no key; multi-row patterns are ghosting.
    assign single  = (rs != '0) && ((rs & (rs - ROWS'(1))) == '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pat_nx   = pat;
        row_nx   = row_idx;
        held_nx  = key_held;
        accept   = 1'b0;
        rotate   = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (single) begin
                        pat_nx   = rs;
                        row_nx   = onehot_idx(rs);
                        cnt_nx   = 4'd1;
                        state_nx = ST_DEBOUNCE;
                    end else begin
                        rotate = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs == pat) begin
                        if (cnt_inc >= 5'(DEB_TICKS)) begin
                            accept   = 1'b1;
                            held_nx  = 1'b1;
                            cnt_nx   = 4'd0;
                            state_nx = ST_HELD;
                        end else begin
                            cnt_nx = cnt_inc[3:0];
                        end
                    end else begin
                        cnt_nx   = 4'd0;
                        rotate   = 1'b1;
                        state_nx = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Any row activity, including a second key, restarts the release count.
                    if (rs == '0) begin
                        if (cnt_inc >= 5'(DEB_TICKS)) begin
                            held_nx  = 1'b0;
                            cnt_nx   = 4'd0;
                            state_nx = ST_SCAN;
                        end else begin
                            cnt_nx = cnt_inc[3:0];
                        end
                    end else begin
                        cnt_nx = 4'd0;
                    end
                end
                default: begin
                    cnt_nx   = 4'd0;
                    state_nx = ST_SCAN;
                end
            endcase
        end
    end

`ifdef KEYPAD_SEG7_EN
    function automatic logic [6:0] seg_decode(input logic [CW-1:0] code);
        case (int'(code))
            0:       seg_decode = 7'b1111001;
            1:       seg_decode = 7'b0100100;
            2:       seg_decode = 7'b0110000;
            3:       seg_decode = 7'b0011001;
            4:       seg_decode = 7'b0010010;
            5:       seg_decode = 7'b0000011;
            6:       seg_decode = 7'b1111000;
            7:       seg_decode = 7'b0000000;
            8:       seg_decode = 7'b0011000;
            9:       seg_decode = 7'b0110010;
            10:      seg_decode = 7'b1000000;
            11:      seg_decode = 7'b1110000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [CW-1:0] code_new;
    assign code_new = CW'(int'(row_idx) * COLS + int'(col_idx));

    always_ff @(posedge ck) begin
        if (rst) begin
            s <= 7'h7F;
        end else if (accept) begin
            s <= seg_decode(code_new);
        end
    end
`endif

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= ST_SCAN;
            r_meta    <= '0;
            rs        <= '0;
            pat       <= '0;
            div       <= '0;
            cnt       <= 4'd0;
            C         <= COLS'(1);
            col_idx   <= '0;
            row_idx   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            r_meta    <= R;
            rs        <= r_meta;
            div       <= div + DIV_W'(1);
            state     <= state_nx;
            cnt       <= cnt_nx;
            pat       <= pat_nx;
            row_idx   <= row_nx;
            key_held  <= held_nx;
            key_valid <= accept;
            if (rotate) begin
                C       <= {C[COLS-2:0], C[COLS-1]};
                col_idx <= (int'(col_idx) == COLS - 1) ? '0 : col_idx + CLW'(1);
            end
            if (accept) begin
                key_code <= CW'(int'(row_idx) * COLS + int'(col_idx));
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_deb.sv
// tb/tb_keypad_scan_deb.sv - directed and random keypad scenarios against a tick-level reference
module tb_keypad_scan_deb;
    localparam int ROWS = 4, COLS = 3, DIV_W = 2, DEB_TICKS = 3, CW = 4, TCK = 4;
    localparam int M_IDLE = 0, M_CONFIRM = 1, M_DOWN = 2;
    localparam logic [6:0] SEG [12] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000011, 7'b1111000, 7'b0000000,
                                        7'b0011000, 7'b0110010, 7'b1000000, 7'b1110000};

    logic            ck = 1'b0;
    logic            rst = 1'b1;
    logic [ROWS-1:0] R = '0;
    logic [COLS-1:0] C;
    logic [CW-1:0]   key_code;
    logic            key_valid, key_held;
`ifdef KEYPAD_SEG7_EN
    logic [6:0]      s;
`endif

    always #5 ck = ~ck;

    keypad_scan_deb #(.ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W), .DEB_TICKS(DEB_TICKS)) dut (
        .ck(ck), .rst(rst), .R(R), .C(C), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held)
`ifdef KEYPAD_SEG7_EN
        , .s(s)
`endif
    );

    int tests = 0, fails = 0, vcount = 0;
    int m_cyc, m_col, m_mode, m_runs, m_code;
    logic [3:0] m_sync [2];
    logic [3:0] m_pat;
    bit m_valid, m_held;
    logic [6:0] m_seg;
    int p_kind = 0, p_row = 0, p_col = 0;
    logic [3:0] p_raw = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Keypad emulation: a pressed key connects its row to the strobe of its own column.
    function automatic logic [3:0] drive_r();
        logic [3:0] r = '0;
        if (p_kind == 1 && m_col == p_col) r[p_row] = 1'b1;
        if (p_kind == 2 && m_col == p_col) begin
            r[p_row] = 1'b1;
            r[(p_row + 1) % ROWS] = 1'b1;
        end
        if (p_kind == 3) r = p_raw;
        return r;
    endfunction

    task automatic model_edge(input logic rst_v, input logic [3:0] r_v);
        logic [3:0] seen;
        int row;
        if (rst_v) begin
            m_cyc = 0; m_col = 0; m_mode = M_IDLE; m_runs = 0; m_code = 0;
            m_sync[0] = '0; m_sync[1] = '0; m_pat = '0;
            m_valid = 0; m_held = 0; m_seg = 7'h7F;
            return;
        end
        seen = m_sync[1];
        m_valid = 0;
        if (m_cyc % TCK == TCK - 1) begin
            if (m_mode == M_IDLE) begin
                if ($countones(seen) == 1) begin
                    m_pat = seen; m_runs = 1; m_mode = M_CONFIRM;
                end else m_col = (m_col + 1) % COLS;
            end else if (m_mode == M_CONFIRM) begin
                if (seen == m_pat) begin
                    m_runs++;
                    if (m_runs >= DEB_TICKS) begin
                        row = 0;
                        for (int i = 0; i < ROWS; i++) if (m_pat[i]) row = i;
                        m_code = row * COLS + m_col;
                        m_valid = 1; m_held = 1; m_runs = 0; m_mode = M_DOWN;
                        m_seg = (m_code < 12) ? SEG[m_code] : 7'h7F;
                    end
                end else begin
                    m_runs = 0; m_mode = M_IDLE; m_col = (m_col + 1) % COLS;
                end
            end else begin
                if (seen == 0) begin
                    m_runs++;
                    if (m_runs == DEB_TICKS) begin
                        m_held = 0; m_runs = 0; m_mode = M_IDLE;
                    end
                end else m_runs = 0;
            end
        end
        m_cyc++;
        m_sync[1] = m_sync[0];
        m_sync[0] = r_v;
    endtask

    task automatic cyc();
        R = drive_r();
        @(posedge ck);
        model_edge(rst, R);
        #1;
        if (key_valid === 1'b1) vcount++;
        check("C", 32'(C), 32'(1) << m_col);
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_held", 32'(key_held), 32'(m_held));
        check("key_code", 32'(key_code), 32'(m_code));
`ifdef KEYPAD_SEG7_EN
        check("s", 32'(s), 32'(m_seg));
`endif
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n * TCK; i++) cyc();
    endtask

    initial begin
        rst = 1'b1;
        cyc(); cyc();
        check("rst_C", 32'(C), 32'd1);
        check("rst_held", 32'(key_held), 32'd0);
        rst = 1'b0;

        vcount = 0;
        p_kind = 0;
        run_ticks(6);
        check("idle_no_valid", 32'(vcount), 32'd0);

        vcount = 0;
        p_kind = 1; p_row = 1; p_col = 1;
        run_ticks(10);
        check("key5_code", 32'(key_code), 32'd4);
        check("key5_held", 32'(key_held), 32'd1);
        check("key5_C", 32'(C), 32'b010);
        check("key5_one_pulse", 32'(vcount), 32'd1);
`ifdef KEYPAD_SEG7_EN
        check("key5_seg", 32'(s), 32'b0010010);
`endif

        p_kind = 0;
        run_ticks(2);
        check("release_short_held", 32'(key_held), 32'd1);
        run_ticks(3);
        check("release_full_held", 32'(key_held), 32'd0);

        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            p_kind = (i % 2 == 0) ? 1 : 0;
            run_ticks(1);
        end
        p_kind = 0;
        run_ticks(2);
        check("bounce_no_valid", 32'(vcount), 32'd0);

        vcount = 0;
        p_kind = 3; p_raw = 4'b0011;
        run_ticks(12);
        check("ghost_no_valid", 32'(vcount), 32'd0);
        check("ghost_not_held", 32'(key_held), 32'd0);

        p_kind = 1; p_row = 3; p_col = 2;
        run_ticks(10);
        check("hash_code", 32'(key_code), 32'd11);
        check("hash_held", 32'(key_held), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_held_C", 32'(C), 32'd1);
        check("rst_held_flag", 32'(key_held), 32'd0);
        check("rst_held_code", 32'(key_code), 32'd0);
        check("rst_held_valid", 32'(key_valid), 32'd0);

        p_kind = 0;
        for (int seg = 0; seg < 60; seg++) begin
            p_kind = $urandom_range(0, 3);
            p_row  = $urandom_range(0, ROWS - 1);
            p_col  = $urandom_range(0, COLS - 1);
            p_raw  = 4'($urandom_range(0, 15));
            run_ticks($urandom_range(1, 8));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
